// File: rtl/chunked_adder_sequencer.sv
// Sequences a W = N*WORDS bit add through an external N-bit adder, LS slice first.
// Optional macro CHUNK_EARLY_DONE_EN: leave RUN early once the remaining slices can only produce zeros.
module chunked_adder_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  output logic [1:0]           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready/out_valid are registered and depend only on state, never on in_valid/out_ready.

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [IW-1:0]   idx;
  logic            c_reg;
  logic            last_slice;
  logic            early_exit;

  assign state_dbg  = state;
  assign last_slice = (idx == IW'(WORDS - 1));

`ifdef CHUNK_EARLY_DONE_EN
  logic upper_zero;
  // Nothing left above this slice and no carry out: upper sum slices stay at their cleared zeros.
  assign upper_zero = (((a_reg | b_reg) >> ((int'(idx) + 1) * N)) == '0);
  assign early_exit = !add_cout && upper_zero && !last_slice;
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[int'(idx)*N +: N];
      add_b   = b_reg[int'(idx)*N +: N];
      add_cin = c_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      c_reg     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            c_reg    <= cin;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*N +: N] <= add_sum;
          c_reg                 <= add_cout;
          idx                   <= idx + 1'b1;
          if (last_slice || early_exit) begin
            // On an early exit add_cout is 0, so this is the right final carry either way.
            cout      <= add_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed bench for chunked_adder_sequencer (N=4, WORDS=4) with a behavioural slice adder.
module tb_chunked_adder_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum;
  logic            cout;
  logic [N-1:0]    add_a;
  logic [N-1:0]    add_b;
  logic            add_cin;
  logic [N-1:0]    add_sum;
  logic            add_cout;
  logic [1:0]      state_dbg;

  int n_cmp;
  int n_err;
  logic [W:0]   exp_q[$];
  logic [N-1:0] a_seq[$];

  chunked_adder_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .state_dbg (state_dbg)
  );

  // External combinational slice adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, wait for DONE, compare result and RUN latency; leaves DUT in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input int exp_lat);
    int lat;
    logic [W:0] e;
    check({tag, "_in_ready"}, in_ready, 1);
    exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin});
    a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'b1;
    lat = 0;
    a_seq.delete();
    while (!out_valid && lat < 20) begin
      a_seq.push_back(add_a);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_sum"}, sum, e[W-1:0]);
    check({tag, "_cout"}, cout, e[W]);
    check({tag, "_busy"}, in_ready, 0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_in_ready"}, in_ready, 1);
    check({tag, "_rel_out_valid"}, out_valid, 0);
    check({tag, "_rel_add_a"}, add_a, 0);
  endtask

  initial begin
    logic seen;
    int   t0, t1, got, lat2;
    logic [W:0] e;
    int   exp_short;
    n_cmp = 0; n_err = 0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Power-on reset values
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of RUN
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_add_a", add_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("midrst_no_result", seen, 0);
    check("midrst_idle", in_ready, 1);

`ifdef CHUNK_EARLY_DONE_EN
    exp_short = 1;
`else
    exp_short = 4;
`endif

    // Full carry ripple
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 4);
    check("ripple_sum_const", sum, 16'h0000);
    check("ripple_cout_const", cout, 1);
    release_result("ripple");

    // Generic add, add_a slice order
    run_op("generic", 16'h1234, 16'hABCD, 1'b0, 4);
    check("generic_sum_const", sum, 16'hBE01);
    check("generic_nslices", a_seq.size(), 4);
    if (a_seq.size() == 4) begin
      check("generic_add_a0", a_seq[0], 4'h4);
      check("generic_add_a1", a_seq[1], 4'h3);
      check("generic_add_a2", a_seq[2], 4'h2);
      check("generic_add_a3", a_seq[3], 4'h1);
    end

    // Backpressure with stray in_valid
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 16'hBE01);
      check("bp_cout", cout, 0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_no_capture_sum", sum, 16'hBE01);
    @(posedge clk); #1;
    check("bp_still_idle", in_ready, 1);

    // Early done candidate
    run_op("early", 16'h0003, 16'h0004, 1'b0, exp_short);
    check("early_sum_const", sum, 16'h0007);
    release_result("early");

    // Boundary: carry out of top slice with zero sum
    run_op("top", 16'h8000, 16'h8000, 1'b0, 4);
    release_result("top");

    // Back-to-back with both handshakes tied high
    lat2 = exp_short;
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b0, 16'h0002});
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
    got = 0; t0 = -1; t1 = -1;
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        a = 16'h0001; b = 16'h0001;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        check("b2b_sum", sum, e[W-1:0]);
        check("b2b_cout", cout, e[W]);
        if (got == 0) t0 = cyc;
        else t1 = cyc;
        got++;
        if (got == 2) in_valid = 1'b0;
      end
    end
    check("b2b_count", got, 2);
    check("b2b_first_lat", t0, 4);
    check("b2b_gap", t1 - t0, lat2 + 2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_end_idle", in_ready, 1);
    check("b2b_end_out_valid", out_valid, 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
